// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding, load-use stall and flush
// Operands are forwarded combinationally from EX/MEM/WB; load-use hazards insert one bubble.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rD1,
    input  logic [XLEN-1:0]  id_rD2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [3:0]       id_op,
    input  logic             id_sel,
    input  logic             id_rf_we,
    input  logic             id_ram_we,
    input  logic             id_is_load,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic [1:0]       id_wd_sel,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_we,
    input  logic             wb_we,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic [XLEN-1:0]  wb_fwd_data,
    input  logic             flush,
    input  logic             hold,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_data1,
    output logic [XLEN-1:0]  ex_data2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [3:0]       ex_op,
    output logic             ex_sel,
    output logic [4:0]       ex_rd,
    output logic             ex_rf_we,
    output logic             ex_ram_we,
    output logic             ex_is_load,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [1:0]       ex_wd_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
        logic [3:0]      op;
        logic            sel;
        logic [4:0]      rd;
        logic            rf_we;
        logic            ram_we;
        logic            is_load;
        logic            branch;
        logic            jump;
        logic [1:0]      wd_sel;
    } ex_reg_t;

    ex_reg_t          ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            ex_wr;
    logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic [XLEN-1:0] data1_fwd, data2_fwd;
    logic            load_use;
    logic            take, kill;

    // A loading EX instruction has no result yet, so it never forwards.
    assign ex_wr    = ex_q.valid & ex_q.rf_we;
    assign ex_hit1  = ex_wr & ~ex_q.is_load & (id_rs1 != 5'd0) & (ex_q.rd == id_rs1);
    assign ex_hit2  = ex_wr & ~ex_q.is_load & (id_rs2 != 5'd0) & (ex_q.rd == id_rs2);
    assign mem_hit1 = mem_we & (id_rs1 != 5'd0) & (mem_rd == id_rs1);
    assign mem_hit2 = mem_we & (id_rs2 != 5'd0) & (mem_rd == id_rs2);
    assign wb_hit1  = wb_we & (id_rs1 != 5'd0) & (wb_rd == id_rs1);
    assign wb_hit2  = wb_we & (id_rs2 != 5'd0) & (wb_rd == id_rs2);

    assign data1_fwd = ex_hit1  ? ex_fwd_data  :
                       mem_hit1 ? mem_fwd_data :
                       wb_hit1  ? wb_fwd_data  : id_rD1;
    assign data2_fwd = ex_hit2  ? ex_fwd_data  :
                       mem_hit2 ? mem_fwd_data :
                       wb_hit2  ? wb_fwd_data  : id_rD2;

    assign load_use = id_valid & ex_wr & ex_q.is_load & (ex_q.rd != 5'd0) &
                      ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    assign id_stall = load_use & ~flush & ~rst;

    // Flush beats hold; hold beats the load-use bubble.
    assign kill = flush | (~hold & load_use);
    assign take = ~flush & ~hold & ~load_use;

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (take) begin
            ex_d.valid   = id_valid;
            ex_d.pc      = id_pc;
            ex_d.data1   = data1_fwd;
            ex_d.data2   = data2_fwd;
            ex_d.imm     = id_imm;
            ex_d.op      = id_op;
            ex_d.sel     = id_sel;
            ex_d.rd      = id_rd;
            ex_d.rf_we   = id_rf_we & id_valid;
            ex_d.ram_we  = id_ram_we & id_valid;
            ex_d.is_load = id_is_load & id_valid;
            ex_d.branch  = id_branch & id_valid;
            ex_d.jump    = id_jump & id_valid;
            ex_d.wd_sel  = id_wd_sel;
        end
        if (kill) begin
            ex_d.valid   = 1'b0;
            ex_d.rf_we   = 1'b0;
            ex_d.ram_we  = 1'b0;
            ex_d.is_load = 1'b0;
            ex_d.branch  = 1'b0;
            ex_d.jump    = 1'b0;
        end
        if (~flush & ~hold & load_use & (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_pc      = ex_q.pc;
    assign ex_data1   = ex_q.data1;
    assign ex_data2   = ex_q.data2;
    assign ex_imm     = ex_q.imm;
    assign ex_op      = ex_q.op;
    assign ex_sel     = ex_q.sel;
    assign ex_rd      = ex_q.rd;
    assign ex_rf_we   = ex_q.rf_we;
    assign ex_ram_we  = ex_q.ram_we;
    assign ex_is_load = ex_q.is_load;
    assign ex_branch  = ex_q.branch;
    assign ex_jump    = ex_q.jump;
    assign ex_wd_sel  = ex_q.wd_sel;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized check of id_ex_stage against a behavioural model
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, id_valid, id_sel, id_rf_we, id_ram_we, id_is_load, id_branch, id_jump;
    logic [XLEN-1:0] id_pc, id_rD1, id_rD2, id_imm, ex_fwd_data, mem_fwd_data, wb_fwd_data;
    logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [3:0] id_op;
    logic [1:0] id_wd_sel;
    logic mem_we, wb_we, flush, hold;
    logic id_stall, ex_valid, ex_sel, ex_rf_we, ex_ram_we, ex_is_load, ex_branch, ex_jump;
    logic [XLEN-1:0] ex_pc, ex_data1, ex_data2, ex_imm;
    logic [3:0] ex_op;
    logic [4:0] ex_rd;
    logic [1:0] ex_wd_sel;
    logic [CNT_W-1:0] stall_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rD1(id_rD1), .id_rD2(id_rD2),
        .id_imm(id_imm), .id_op(id_op), .id_sel(id_sel), .id_rf_we(id_rf_we),
        .id_ram_we(id_ram_we), .id_is_load(id_is_load), .id_branch(id_branch),
        .id_jump(id_jump), .id_wd_sel(id_wd_sel), .ex_fwd_data(ex_fwd_data),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_we(mem_we), .wb_we(wb_we),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .flush(flush), .hold(hold),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data1(ex_data1),
        .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_op(ex_op), .ex_sel(ex_sel), .ex_rd(ex_rd),
        .ex_rf_we(ex_rf_we), .ex_ram_we(ex_ram_we), .ex_is_load(ex_is_load),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_wd_sel(ex_wd_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state of the EX register as seen by the program order model.
    logic            m_valid = 0, m_sel = 0, m_rf_we = 0, m_ram_we = 0;
    logic            m_is_load = 0, m_branch = 0, m_jump = 0;
    logic [XLEN-1:0] m_pc = 0, m_d1 = 0, m_d2 = 0, m_imm = 0;
    logic [3:0]      m_op = 0;
    logic [4:0]      m_rd = 0;
    logic [1:0]      m_wd = 0;
    int              m_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Newest producer wins; a load still in EX has no value to give.
    function automatic logic [XLEN-1:0] operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 0) return rf;
        if (m_valid && m_rf_we && !m_is_load && m_rd == rs) return ex_fwd_data;
        if (mem_we && mem_rd == rs) return mem_fwd_data;
        if (wb_we && wb_rd == rs) return wb_fwd_data;
        return rf;
    endfunction

    task automatic idle_inputs();
        rst = 0; id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rD1 = 0; id_rD2 = 0; id_imm = 0; id_op = 0; id_sel = 0; id_rf_we = 0;
        id_ram_we = 0; id_is_load = 0; id_branch = 0; id_jump = 0; id_wd_sel = 0;
        ex_fwd_data = 0; mem_rd = 0; wb_rd = 0; mem_we = 0; wb_we = 0;
        mem_fwd_data = 0; wb_fwd_data = 0; flush = 0; hold = 0;
    endtask

    // Inputs are set just after a falling edge; this checks the stall, clocks once, checks EX.
    task automatic step();
        logic lu;
        logic [XLEN-1:0] f1, f2;
        #1;
        lu = id_valid && m_valid && m_is_load && m_rf_we && m_rd != 0 &&
             (m_rd == id_rs1 || m_rd == id_rs2);
        chk("id_stall", {63'd0, id_stall}, {63'd0, lu && !flush && !rst});
        f1 = operand(id_rs1, id_rD1);
        f2 = operand(id_rs2, id_rD2);
        if (rst) begin
            m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_op = 0; m_sel = 0;
            m_rd = 0; m_rf_we = 0; m_ram_we = 0; m_is_load = 0; m_branch = 0; m_jump = 0;
            m_wd = 0; m_cnt = 0;
        end else if (flush || (!hold && lu)) begin
            if (!flush && m_cnt < CMAX) m_cnt++;
            m_valid = 0; m_rf_we = 0; m_ram_we = 0; m_is_load = 0; m_branch = 0; m_jump = 0;
        end else if (!hold) begin
            m_valid = id_valid; m_pc = id_pc; m_d1 = f1; m_d2 = f2; m_imm = id_imm;
            m_op = id_op; m_sel = id_sel; m_rd = id_rd; m_wd = id_wd_sel;
            m_rf_we = id_rf_we && id_valid; m_ram_we = id_ram_we && id_valid;
            m_is_load = id_is_load && id_valid; m_branch = id_branch && id_valid;
            m_jump = id_jump && id_valid;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
        chk("ex_flags", {59'd0, ex_rf_we, ex_ram_we, ex_is_load, ex_branch, ex_jump},
            {59'd0, m_rf_we, m_ram_we, m_is_load, m_branch, m_jump});
        chk("stall_cnt", {{(64-CNT_W){1'b0}}, stall_cnt}, 64'(m_cnt));
        if (m_valid) begin
            chk("ex_pc", {32'd0, ex_pc}, {32'd0, m_pc});
            chk("ex_data1", {32'd0, ex_data1}, {32'd0, m_d1});
            chk("ex_data2", {32'd0, ex_data2}, {32'd0, m_d2});
            chk("ex_imm", {32'd0, ex_imm}, {32'd0, m_imm});
            chk("ex_ctl", {50'd0, ex_op, ex_sel, ex_rd, ex_wd_sel},
                {50'd0, m_op, m_sel, m_rd, m_wd});
        end
        @(negedge clk);
    endtask

    task automatic load_into_ex(input logic [4:0] rd);
        idle_inputs();
        id_valid = 1; id_rd = rd; id_rf_we = 1; id_is_load = 1; id_wd_sel = 2'd1;
        step();
    endtask

    logic [XLEN-1:0] held_pc;

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        step();
        step();
        chk("reset_pc", {32'd0, ex_pc}, 64'd0);
        chk("reset_op", {60'd0, ex_op}, 64'd0);
        chk("reset_data1", {32'd0, ex_data1}, 64'd0);

        // ADD x5 followed by ADD x6,x5,x5
        idle_inputs(); id_valid = 1; id_rd = 5; id_rf_we = 1; id_pc = 32'h100; step();
        idle_inputs(); id_valid = 1; id_rs1 = 5; id_rs2 = 5; id_rd = 6; id_rf_we = 1;
        ex_fwd_data = 32'h10; id_rD1 = 32'h99; id_rD2 = 32'h98; step();
        chk("fwd_ex_d1", {32'd0, ex_data1}, 64'h10);
        chk("fwd_ex_d2", {32'd0, ex_data2}, 64'h10);

        // LW x7 then a reader: one bubble, then the load value comes from MEM
        load_into_ex(7);
        idle_inputs(); id_valid = 1; id_rs1 = 7; id_rf_we = 1; id_rd = 8; id_rD1 = 32'h1; step();
        chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
        chk("lu_cnt", {{(64-CNT_W){1'b0}}, stall_cnt}, 64'd1);
        mem_we = 1; mem_rd = 7; mem_fwd_data = 32'hDEADBEEF; step();
        chk("lu_mem_fwd", {32'd0, ex_data1}, 64'hDEADBEEF);

        // MEM beats WB; WB used when MEM does not match
        idle_inputs(); id_valid = 1; id_rs1 = 3; mem_we = 1; mem_rd = 3; mem_fwd_data = 32'h11;
        wb_we = 1; wb_rd = 3; wb_fwd_data = 32'h22; step();
        chk("mem_over_wb", {32'd0, ex_data1}, 64'h11);
        mem_we = 0; step();
        chk("wb_fwd", {32'd0, ex_data1}, 64'h22);

        // x0 is never forwarded
        idle_inputs(); id_valid = 1; id_rs1 = 0; mem_we = 1; mem_rd = 0; mem_fwd_data = 32'h55;
        step();
        chk("x0_nofwd", {32'd0, ex_data1}, 64'd0);

        // flush together with hold, then hold alone for three cycles
        idle_inputs(); id_valid = 1; id_rd = 9; id_rf_we = 1; flush = 1; hold = 1; step();
        chk("flush_hold_v", {63'd0, ex_valid}, 64'd0);
        chk("flush_hold_we", {63'd0, ex_rf_we}, 64'd0);
        idle_inputs(); id_valid = 1; id_rd = 9; id_rf_we = 1; id_pc = 32'h2000; step();
        held_pc = ex_pc;
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); hold = 1; id_valid = 1; id_pc = 32'h3000 + i; id_rd = 4; step();
        end
        chk("hold_pc", {32'd0, ex_pc}, {32'd0, held_pc});
        chk("hold_v", {63'd0, ex_valid}, 64'd1);

        // saturate the stall counter
        for (int i = 0; i < CMAX + 3; i++) begin
            load_into_ex(7);
            idle_inputs(); id_valid = 1; id_rs2 = 7; step();
        end
        chk("cnt_sat", {{(64-CNT_W){1'b0}}, stall_cnt}, 64'(CMAX));

        // reset in the middle of a load-use stall
        load_into_ex(7);
        idle_inputs(); id_valid = 1; id_rs1 = 7; rst = 1; step();
        chk("rst_cnt", {{(64-CNT_W){1'b0}}, stall_cnt}, 64'd0);
        chk("rst_valid", {63'd0, ex_valid}, 64'd0);
        idle_inputs(); id_valid = 1; id_rs1 = 7; step();

        // randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            rst        = ($urandom_range(99) < 2);
            flush      = ($urandom_range(99) < 8);
            hold       = ($urandom_range(99) < 12);
            id_valid   = ($urandom_range(99) < 85);
            id_pc      = $urandom; id_imm = $urandom; id_rD1 = $urandom; id_rD2 = $urandom;
            id_rs1     = 5'($urandom_range(3)); id_rs2 = 5'($urandom_range(3));
            id_rd      = 5'($urandom_range(3));
            id_op      = 4'($urandom); id_sel = 1'($urandom); id_wd_sel = 2'($urandom);
            id_rf_we   = 1'($urandom); id_ram_we = 1'($urandom);
            id_is_load = ($urandom_range(99) < 35);
            id_branch  = 1'($urandom); id_jump = 1'($urandom);
            ex_fwd_data = $urandom; mem_fwd_data = $urandom; wb_fwd_data = $urandom;
            mem_rd     = 5'($urandom_range(3)); wb_rd = 5'($urandom_range(3));
            mem_we     = 1'($urandom); wb_we = 1'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
